// File: rtl/ad9833_sweep_ctrl.sv
// AD9833 frequency-sweep sequencer: issues RSTW/LSB/MSB/CTRL words to a shift engine and dwells per step.
// Define AD9833_SWEEP_PARK_EN to send a final RSTW (DAC parked at midscale) at the end of every non-timeout sweep.
module ad9833_sweep_ctrl #(
  parameter int unsigned DWELL_W    = 24,
  parameter int unsigned STEP_W     = 16,
  parameter int unsigned TX_TIMEOUT = 4096
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               start,
  input  logic               abort,
  input  logic [27:0]        start_freq,
  input  logic [27:0]        step_freq,
  input  logic [STEP_W-1:0]  num_steps,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [1:0]         mode,
  output logic               tx_go,
  output logic [15:0]        tx_data,
  input  logic               tx_done,
  output logic               busy,
  output logic               done,
  output logic [STEP_W-1:0]  step_idx,
  output logic [27:0]        cur_freq,
  output logic               err_timeout
);

  localparam int unsigned TO_W    = $clog2(TX_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TX_TIMEOUT - 1);
  localparam logic [15:0] RSTW    = 16'h2100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DWELL
`ifdef AD9833_SWEEP_PARK_EN
    ,
    S_PARK_ISSUE,
    S_PARK_WAIT
`endif
  } state_e;

  typedef enum logic [1:0] {
    W_RST,
    W_LSB,
    W_MSB,
    W_CTRL
  } word_e;

  state_e              state_q, state_d;
  word_e               word_q, word_d;
  logic [27:0]         step_q;
  logic [STEP_W-1:0]   last_q;
  logic [DWELL_W-1:0]  dwell_cfg_q;
  logic [1:0]          mode_q;
  logic [27:0]         send_freq_q, send_freq_d;
  logic [STEP_W-1:0]   send_idx_q, send_idx_d;
  logic [27:0]         cur_freq_q, cur_freq_d;
  logic [STEP_W-1:0]   step_idx_q, step_idx_d;
  logic [DWELL_W-1:0]  dwell_cnt_q, dwell_cnt_d;
  logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
  logic                abort_q, abort_d;
  logic                err_q, err_d;
  logic                done_q, done_d;
  logic [15:0]         tx_data_q, tx_data_d;
  logic                start_acc;
  logic                end_sweep;
  logic                abort_req;

  function automatic logic [15:0] ctrl_word(input logic [1:0] m);
    logic [15:0] w;
    unique case (m)
      2'b00:   w = 16'h2000;
      2'b01:   w = 16'h2002;
      2'b10:   w = 16'h2028;
      default: w = 16'h2020;
    endcase
    return w;
  endfunction

  assign abort_req = abort_q | abort;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      word_q      <= W_RST;
      step_q      <= '0;
      last_q      <= '0;
      dwell_cfg_q <= '0;
      mode_q      <= '0;
      send_freq_q <= '0;
      send_idx_q  <= '0;
      cur_freq_q  <= '0;
      step_idx_q  <= '0;
      dwell_cnt_q <= '0;
      to_cnt_q    <= '0;
      abort_q     <= 1'b0;
      err_q       <= 1'b0;
      done_q      <= 1'b0;
      tx_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      send_freq_q <= send_freq_d;
      send_idx_q  <= send_idx_d;
      cur_freq_q  <= cur_freq_d;
      step_idx_q  <= step_idx_d;
      dwell_cnt_q <= dwell_cnt_d;
      to_cnt_q    <= to_cnt_d;
      abort_q     <= abort_d;
      err_q       <= err_d;
      done_q      <= done_d;
      tx_data_q   <= tx_data_d;
      if (start_acc) begin
        step_q      <= step_freq;
        last_q      <= (num_steps == '0) ? '0 : num_steps - STEP_W'(1);
        dwell_cfg_q <= dwell;
        mode_q      <= mode;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    send_freq_d = send_freq_q;
    send_idx_d  = send_idx_q;
    cur_freq_d  = cur_freq_q;
    step_idx_d  = step_idx_q;
    dwell_cnt_d = dwell_cnt_q;
    to_cnt_d    = to_cnt_q;
    err_d       = err_q;
    done_d      = 1'b0;
    start_acc   = 1'b0;
    end_sweep   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          start_acc   = 1'b1;
          state_d     = S_ISSUE;
          word_d      = W_RST;
          send_freq_d = start_freq;
          send_idx_d  = '0;
          err_d       = 1'b0;
        end
      end

      S_ISSUE: begin
        to_cnt_d = '0;
        state_d  = S_WAIT;
      end

      S_WAIT: begin
        if (tx_done) begin
          // The applied frequency only changes once its MSB half has reached the part.
          if (word_q == W_MSB) begin
            cur_freq_d = send_freq_q;
            step_idx_d = send_idx_q;
          end
          if (abort_req) begin
            end_sweep = 1'b1;
          end else begin
            unique case (word_q)
              W_RST: begin
                word_d  = W_LSB;
                state_d = S_ISSUE;
              end
              W_LSB: begin
                word_d  = W_MSB;
                state_d = S_ISSUE;
              end
              W_MSB: begin
                if (send_idx_q == '0) begin
                  word_d  = W_CTRL;
                  state_d = S_ISSUE;
                end else begin
                  dwell_cnt_d = dwell_cfg_q;
                  state_d     = S_DWELL;
                end
              end
              default: begin
                dwell_cnt_d = dwell_cfg_q;
                state_d     = S_DWELL;
              end
            endcase
          end
        end else if (to_cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end

      S_DWELL: begin
        if (abort_req) begin
          end_sweep = 1'b1;
        end else if (dwell_cnt_q == '0) begin
          if (step_idx_q == last_q) begin
            end_sweep = 1'b1;
          end else begin
            send_idx_d  = step_idx_q + STEP_W'(1);
            send_freq_d = cur_freq_q + step_q;
            word_d      = W_LSB;
            state_d     = S_ISSUE;
          end
        end else begin
          dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
        end
      end

`ifdef AD9833_SWEEP_PARK_EN
      S_PARK_ISSUE: begin
        to_cnt_d = '0;
        state_d  = S_PARK_WAIT;
      end

      S_PARK_WAIT: begin
        if (tx_done) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (to_cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
`endif

      default: state_d = S_IDLE;
    endcase

    if (end_sweep) begin
`ifdef AD9833_SWEEP_PARK_EN
      state_d = S_PARK_ISSUE;
`else
      state_d = S_IDLE;
      done_d  = 1'b1;
`endif
    end

    // Abort is remembered across ISSUE/WAIT so an in-flight word still completes first.
    abort_d = (state_q != S_IDLE && state_d != S_IDLE) ? abort_req : 1'b0;
  end

  always_comb begin
    tx_data_d = tx_data_q;
    if (state_d == S_ISSUE && state_q != S_ISSUE) begin
      unique case (word_d)
        W_RST:   tx_data_d = RSTW;
        W_LSB:   tx_data_d = {2'b01, send_freq_d[13:0]};
        W_MSB:   tx_data_d = {2'b01, send_freq_d[27:14]};
        default: tx_data_d = ctrl_word(mode_q);
      endcase
    end
`ifdef AD9833_SWEEP_PARK_EN
    if (state_d == S_PARK_ISSUE && state_q != S_PARK_ISSUE) begin
      tx_data_d = RSTW;
    end
`endif
  end

  always_comb begin
    tx_go = (state_q == S_ISSUE);
`ifdef AD9833_SWEEP_PARK_EN
    tx_go = tx_go | (state_q == S_PARK_ISSUE);
`endif
    busy        = (state_q != S_IDLE);
    done        = done_q;
    tx_data     = tx_data_q;
    step_idx    = step_idx_q;
    cur_freq    = cur_freq_q;
    err_timeout = err_q;
  end

endmodule

// File: tb/tb_ad9833_sweep_ctrl.sv
// Scoreboard bench for ad9833_sweep_ctrl: a behavioural model queues expected command words, a monitor checks them.
module tb_ad9833_sweep_ctrl;

  localparam int unsigned TO = 32;
`ifdef AD9833_SWEEP_PARK_EN
  localparam bit PARK = 1'b1;
`else
  localparam bit PARK = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        resetn;
  logic        start;
  logic        abort;
  logic [27:0] start_freq;
  logic [27:0] step_freq;
  logic [15:0] num_steps;
  logic [23:0] dwell;
  logic [1:0]  mode;
  logic        tx_go;
  logic [15:0] tx_data;
  logic        tx_done;
  logic        busy;
  logic        done;
  logic [15:0] step_idx;
  logic [27:0] cur_freq;
  logic        err_timeout;

  ad9833_sweep_ctrl #(
    .DWELL_W   (24),
    .STEP_W    (16),
    .TX_TIMEOUT(TO)
  ) dut (
    .clock      (clock),
    .resetn     (resetn),
    .start      (start),
    .abort      (abort),
    .start_freq (start_freq),
    .step_freq  (step_freq),
    .num_steps  (num_steps),
    .dwell      (dwell),
    .mode       (mode),
    .tx_go      (tx_go),
    .tx_data    (tx_data),
    .tx_done    (tx_done),
    .busy       (busy),
    .done       (done),
    .step_idx   (step_idx),
    .cur_freq   (cur_freq),
    .err_timeout(err_timeout)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] sb[$];
  int          go_cnt = 0;
  int          done_cnt = 0;
  int          last_go = -10;
  int          last_txdone = -10;
  bit          pend = 1'b0;
  logic [15:0] pend_word;
  int          exp_gap_done = -1;
  int          exp_gap_go = -1;

  int eng_delay = 5;
  int eng_slow_delay = 20;
  int eng_slow_word = -1;
  int eng_word = 0;
  bit eng_mute = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Shift-engine stand-in: answers each tx_go with tx_done a fixed number of cycles later.
  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge clock);
      if (tx_go && !eng_mute) begin
        int d;
        d = (eng_word == eng_slow_word) ? eng_slow_delay : eng_delay;
        eng_word++;
        repeat (d - 1) @(posedge clock);
        #1 tx_done = 1'b1;
        @(posedge clock);
        #1 tx_done = 1'b0;
      end
    end
  end

  always @(negedge clock) begin
    if (tx_go) begin
      go_cnt++;
      chk("go_gap", 32'(cyc - last_go >= 2), 32'd1);
      last_go = cyc;
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL extra_word: got 0x%04h, none expected (t=%0t)", tx_data, $time);
      end else begin
        chk("word", 32'(tx_data), 32'(sb.pop_front()));
      end
      pend = 1'b1;
      pend_word = tx_data;
    end
    if (tx_done) begin
      last_txdone = cyc;
      if (pend) begin
        chk("word_held", 32'(tx_data), 32'(pend_word));
        pend = 1'b0;
      end
    end
    if (done) begin
      done_cnt++;
      chk("busy_at_done", 32'(busy), 32'd0);
      if (exp_gap_done >= 0) chk("done_after_txdone", 32'(cyc - last_txdone), 32'(exp_gap_done));
      if (exp_gap_go >= 0) chk("done_after_go", 32'(cyc - last_go), 32'(exp_gap_go));
    end
  end

  function automatic logic [15:0] ctrl_of(input logic [1:0] m);
    logic [15:0] tbl[4];
    tbl = '{16'h2000, 16'h2002, 16'h2028, 16'h2020};
    return tbl[m];
  endfunction

  function automatic logic [27:0] f_at(input logic [27:0] sf, input logic [27:0] st, input int unsigned k);
    longint unsigned v;
    v = (longint'(sf) + longint'(k) * longint'(st)) % 64'h1000_0000;
    return 28'(v);
  endfunction

  function automatic void push_model(input logic [27:0] sf, input logic [27:0] st,
                                     input logic [15:0] ns, input logic [1:0] md);
    int unsigned n;
    n = (ns == 0) ? 1 : ns;
    sb.push_back(16'h2100);
    for (int unsigned k = 0; k < n; k++) begin
      logic [27:0] f;
      f = f_at(sf, st, k);
      sb.push_back({2'b01, f[13:0]});
      sb.push_back({2'b01, f[27:14]});
      if (k == 0) sb.push_back(ctrl_of(md));
    end
    if (PARK) sb.push_back(16'h2100);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic do_start(input logic [27:0] sf, input logic [27:0] st, input logic [15:0] ns,
                          input logic [23:0] dw, input logic [1:0] md);
    @(posedge clock);
    #1;
    start_freq = sf;
    step_freq  = st;
    num_steps  = ns;
    dwell      = dw;
    mode       = md;
    start      = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    int i;
    i = 0;
    while (done_cnt == d0 && i < budget) begin
      @(posedge clock);
      #1;
      i++;
    end
    if (done_cnt == d0) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_wait: got no done within %0d cycles, expected one", budget);
    end
  endtask

  task automatic sweep(input logic [27:0] sf, input logic [27:0] st, input logic [15:0] ns,
                       input logic [23:0] dw, input logic [1:0] md, input int dly, input bit use_model);
    int unsigned n;
    int d0;
    n = (ns == 0) ? 1 : ns;
    if (use_model) push_model(sf, st, ns, md);
    eng_delay     = dly;
    eng_slow_word = -1;
    eng_word      = 0;
    exp_gap_done  = PARK ? 1 : int'(dw) + 2;
    exp_gap_go    = -1;
    d0 = done_cnt;
    do_start(sf, st, ns, dw, md);
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("err_after_start", 32'(err_timeout), 32'd0);
    wait_done(d0, int'(n) * (6 * dly + 20 + int'(dw)) + 200);
    tick(3);
    chk("done_count", 32'(done_cnt - d0), 32'd1);
    chk("words_left", 32'(sb.size()), 32'd0);
    chk("cur_freq", 32'(cur_freq), 32'(f_at(sf, st, n - 1)));
    chk("step_idx", 32'(step_idx), 32'(n - 1));
    chk("busy_end", 32'(busy), 32'd0);
    sb.delete();
  endtask

  initial begin
    int d0;
    int g0;
    int i;
    resetn = 1'b0; start = 1'b0; abort = 1'b0;
    start_freq = '0; step_freq = '0; num_steps = '0; dwell = '0; mode = '0;
    tick(2);
    chk("rst_tx_go", 32'(tx_go), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_step_idx", 32'(step_idx), 32'd0);
    chk("rst_cur_freq", 32'(cur_freq), 32'd0);
    chk("rst_err", 32'(err_timeout), 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    tick(3);
    chk("idle_busy", 32'(busy), 32'd0);

    // Basic sweep with the literal word list.
    sb = '{16'h2100, 16'h4100, 16'h4000, 16'h2000, 16'h4200, 16'h4000, 16'h4300, 16'h4000};
    if (PARK) sb.push_back(16'h2100);
    sweep(28'h0000100, 28'h0000100, 16'd3, 24'd10, 2'b00, 5, 1'b0);

    sweep(28'hFFFFFFF, 28'h0000002, 16'd2, 24'd3, 2'b01, 4, 1'b1);
    sweep(28'h1234567, 28'h0000011, 16'd0, 24'd0, 2'b10, 3, 1'b1);

    // Abort while the step-1 LSB is in flight.
    sb = '{16'h2100, 16'h4100, 16'h4000, 16'h2000, 16'h4200};
    if (PARK) sb.push_back(16'h2100);
    eng_delay = 5; eng_slow_word = 4; eng_word = 0;
    exp_gap_done = 1; exp_gap_go = -1;
    d0 = done_cnt; g0 = go_cnt;
    do_start(28'h0000100, 28'h0000100, 16'd3, 24'd10, 2'b00);
    i = 0;
    while (go_cnt - g0 < 5 && i < 400) begin tick(1); i++; end
    tick(3);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    wait_done(d0, 300);
    tick(3);
    chk("abort_done_count", 32'(done_cnt - d0), 32'd1);
    chk("abort_words_left", 32'(sb.size()), 32'd0);
    chk("abort_step_idx", 32'(step_idx), 32'd0);
    chk("abort_cur_freq", 32'(cur_freq), 32'h0000100);
    chk("abort_busy", 32'(busy), 32'd0);
    sb.delete();
    eng_slow_word = -1;

    // Engine never answers: timeout, then the next start clears the flag.
    eng_mute = 1'b1;
    sb = '{16'h2100};
    exp_gap_done = -1; exp_gap_go = int'(TO) + 1;
    d0 = done_cnt;
    do_start(28'h0000ABC, 28'h0000001, 16'd2, 24'd2, 2'b11);
    wait_done(d0, 200);
    tick(2);
    chk("to_err", 32'(err_timeout), 32'd1);
    chk("to_busy", 32'(busy), 32'd0);
    chk("to_done_count", 32'(done_cnt - d0), 32'd1);
    chk("to_words_left", 32'(sb.size()), 32'd0);
    sb.delete();
    pend = 1'b0;
    eng_mute = 1'b0;
    tick(5);
    chk("to_err_sticky", 32'(err_timeout), 32'd1);
    sweep(28'h0ABC000, 28'h0001000, 16'd2, 24'd1, 2'b11, 2, 1'b1);

    // Reset mid-DWELL; a start while busy must not re-latch configuration.
    eng_delay = 3; eng_slow_word = -1; eng_word = 0;
    exp_gap_done = -1; exp_gap_go = -1;
    push_model(28'h0ABCDEF, 28'h0000010, 16'd2, 2'b01);
    d0 = done_cnt; g0 = go_cnt;
    do_start(28'h0ABCDEF, 28'h0000010, 16'd2, 24'd200, 2'b01);
    i = 0;
    while (go_cnt - g0 < 2 && i < 100) begin tick(1); i++; end
    do_start(28'h1234567, 28'h0000999, 16'd5, 24'd1, 2'b10);
    i = 0;
    while (go_cnt - g0 < 4 && i < 100) begin tick(1); i++; end
    tick(10);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    chk("pre_rst_cur_freq", 32'(cur_freq), 32'h0ABCDEF);
    chk("pre_rst_done", 32'(done_cnt - d0), 32'd0);
    @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_cur_freq", 32'(cur_freq), 32'd0);
    chk("mid_rst_tx_data", 32'(tx_data), 32'd0);
    chk("mid_rst_step_idx", 32'(step_idx), 32'd0);
    chk("mid_rst_tx_go", 32'(tx_go), 32'd0);
    sb.delete();
    pend = 1'b0;
    tick(3);
    @(negedge clock);
    resetn = 1'b1;
    tick(5);
    chk("post_rst_busy", 32'(busy), 32'd0);
    sweep(28'h0000F00, 28'h0000F00, 16'd2, 24'd2, 2'b00, 3, 1'b1);

    for (int r = 0; r < 6; r++) begin
      logic [27:0] sf;
      logic [27:0] st;
      sf = 28'($urandom);
      st = 28'($urandom);
      sweep(sf, st, 16'($urandom_range(0, 4)), 24'($urandom_range(0, 8)),
            2'($urandom_range(0, 3)), int'($urandom_range(2, 6)), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
